serial_feed_arb: RTL

SERIAL_FEED_ARB -- requirements
Module: serial_feed_arb

---
 rtl/serial_feed_arb.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/serial_feed_arb.sv
// serial_feed_arb
// Round-robin arbiter that takes a WIDTH-bit word from one of two requesters.
// It loads the word, then shifts it out MSB-first to a serial pattern detector.
// Detector matches are credited to the requester whose bits caused them.
//
// Ports
//   clk        single rising-edge clock
//   rst        asynchronous active-low reset (0 = reset)
//   req0/req1  requester word-pending flags; data must stay stable while high
//   data0/1    requester words, MSB shifted first
//   ack0/ack1  one-cycle pulse in the LOAD cycle: the word was captured
//   ser_out    serial bit to the detector
//   ser_valid  ser_out carries a live bit this cycle
//   det_clr    one-cycle detector clear, raised in LOAD when the owner changes
//   det_hit    registered match output of the detector
//   cnt_clr    synchronous clear of both hit counters
//   hit_cnt0/1 saturating per-requester match counts
//   owner      requester being shifted (or last shifted)
//   busy       high in LOAD and SHIFT
module serial_feed_arb #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             ack0,
  output logic             ack1,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             det_clr,
  input  logic             det_hit,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] hit_cnt0,
  output logic [CNT_W-1:0] hit_cnt1,
  output logic             owner,
  output logic             busy
);

  localparam int BC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic             owner_q, owner_d;
  logic             rr_last_q, rr_last_d;
  logic             first_q, first_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             det_clr_q, det_clr_d;
  logic             busy_q, busy_d;
  logic             v_d_q;
  logic             o_d_q;
  logic [CNT_W-1:0] hit_cnt0_q, hit_cnt0_d;
  logic [CNT_W-1:0] hit_cnt1_q, hit_cnt1_d;

  logic arb_point_s;
  logic any_req_s;
  logic grant_s;
  logic hit_s;

  // Arbitration decision: only meaningful at IDLE or on the final shift bit.
  always_comb begin
    arb_point_s = (state_q == ST_IDLE) ||
                  ((state_q == ST_SHIFT) && (bit_cnt_q == LAST_BIT));
    any_req_s   = req0 | req1;
    // On a tie, the requester that did not own the previous word wins.
    if (req0 && req1) begin
      grant_s = ~rr_last_q;
    end else if (req0) begin
      grant_s = 1'b0;
    end else begin
      grant_s = 1'b1;
    end
  end

  // Next-state and next-output logic for the IDLE/LOAD/SHIFT sequencer.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    owner_d     = owner_q;
    rr_last_d   = rr_last_q;
    first_d     = first_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    ser_out_d   = 1'b0;
    ser_valid_d = 1'b0;
    det_clr_d   = 1'b0;
    busy_d      = 1'b0;

    if (arb_point_s) begin
      if (any_req_s) begin
        state_d   = ST_LOAD;
        shift_d   = grant_s ? data1 : data0;
        owner_d   = grant_s;
        rr_last_d = grant_s;
        first_d   = 1'b0;
        ack0_d    = ~grant_s;
        ack1_d    = grant_s;
        // The detector only needs clearing when the bit stream changes source.
        det_clr_d = first_q | (grant_s != owner_q);
        busy_d    = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_LOAD: begin
          state_d     = ST_SHIFT;
          ser_valid_d = 1'b1;
          ser_out_d   = shift_q[WIDTH-1];
          shift_d     = {shift_q[WIDTH-2:0], 1'b0};
          bit_cnt_d   = {BC_W{1'b0}};
          busy_d      = 1'b1;
        end
        ST_SHIFT: begin
          state_d     = ST_SHIFT;
          ser_valid_d = 1'b1;
          ser_out_d   = shift_q[WIDTH-1];
          shift_d     = {shift_q[WIDTH-2:0], 1'b0};
          bit_cnt_d   = bit_cnt_q + BC_W'(1);
          busy_d      = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Hit counters: a match is credited one cycle late to match the detector's
  // register stage; clear has priority, and counts stick at the maximum.
  always_comb begin
    hit_s = det_hit & v_d_q;
    if (cnt_clr) begin
      hit_cnt0_d = {CNT_W{1'b0}};
      hit_cnt1_d = {CNT_W{1'b0}};
    end else begin
      hit_cnt0_d = hit_cnt0_q;
      hit_cnt1_d = hit_cnt1_q;
      if (hit_s && !o_d_q && (hit_cnt0_q != CNT_MAX)) begin
        hit_cnt0_d = hit_cnt0_q + CNT_W'(1);
      end else begin
        hit_cnt0_d = hit_cnt0_q;
      end
      if (hit_s && o_d_q && (hit_cnt1_q != CNT_MAX)) begin
        hit_cnt1_d = hit_cnt1_q + CNT_W'(1);
      end else begin
        hit_cnt1_d = hit_cnt1_q;
      end
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= {WIDTH{1'b0}};
      bit_cnt_q   <= {BC_W{1'b0}};
      owner_q     <= 1'b0;
      rr_last_q   <= 1'b1;
      first_q     <= 1'b1;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      det_clr_q   <= 1'b0;
      busy_q      <= 1'b0;
      v_d_q       <= 1'b0;
      o_d_q       <= 1'b0;
      hit_cnt0_q  <= {CNT_W{1'b0}};
      hit_cnt1_q  <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      owner_q     <= owner_d;
      rr_last_q   <= rr_last_d;
      first_q     <= first_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      det_clr_q   <= det_clr_d;
      busy_q      <= busy_d;
      v_d_q       <= ser_valid_q;
      o_d_q       <= owner_q;
      hit_cnt0_q  <= hit_cnt0_d;
      hit_cnt1_q  <= hit_cnt1_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign det_clr   = det_clr_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
  assign hit_cnt0  = hit_cnt0_q;
  assign hit_cnt1  = hit_cnt1_q;

endmodule
